// File: rtl/stopwatch_multidigit_counter.sv
// Stopwatch: multi-digit up/down counter with run/stop/lap FSM, load, soft clear, wrap or saturate.
// Latency: count, state and flags update on the sampling edge; o_Display/o_Zero decode registers.
// Backpressure: none; every i_CLK_EN-qualified cycle in RUNNING/LAP advances the count one step.
//
// Ports:
//   i_SUBCLK      clock (rising edge)
//   i_RST         synchronous active-high reset, overrides everything
//   i_SRST        soft clear: count and lap to 0, LAP drops back to RUNNING
//   i_CLK_EN      count tick qualifier
//   i_START       pulse, toggles run/stop
//   i_LAP         pulse, toggles lap freeze (ignored in STOPPED or with i_START)
//   i_DIR         0 = up, 1 = down
//   i_LOAD        load strobe; i_LOAD_VAL digits clamped to DIGIT_MAX
//   i_LOAD_VAL    value to load, digit 0 in [3:0]
//   o_Count       live count, digit 0 in [3:0]
//   o_Display     lap register in LAP, otherwise o_Count
//   o_Running     high in RUNNING or LAP
//   o_Lap_Active  high in LAP
//   o_Wrap        one-cycle pulse after a wrap or saturation event
//   o_Zero        all digits of o_Count are 0
module stopwatch_multidigit_counter #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_MAX = 9,
  parameter int COUNT_SAT = 0
) (
  input  logic                  i_SUBCLK,
  input  logic                  i_RST,
  input  logic                  i_SRST,
  input  logic                  i_CLK_EN,
  input  logic                  i_START,
  input  logic                  i_LAP,
  input  logic                  i_DIR,
  input  logic                  i_LOAD,
  input  logic [4*DIGITS-1:0]   i_LOAD_VAL,
  output logic [4*DIGITS-1:0]   o_Count,
  output logic [4*DIGITS-1:0]   o_Display,
  output logic                  o_Running,
  output logic                  o_Lap_Active,
  output logic                  o_Wrap,
  output logic                  o_Zero
);

  localparam int         W    = 4 * DIGITS;
  localparam logic [3:0] DMAX = 4'(DIGIT_MAX);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_LAP     = 2'd2
  } state_t;

  state_t       state_q;
  state_t       state_fsm;
  state_t       state_n;
  logic [W-1:0] lap_q;
  logic [W-1:0] step_val;
  logic [W-1:0] load_clamped;
  logic         carry;
  logic         tick;
  logic         wrap_event;
  logic         lap_enter;

  assign tick = i_CLK_EN && (state_q != ST_STOPPED);

  // Ripple carry/borrow: a digit steps only when every lower digit sits at
  // its terminal value. A carry out of the top digit marks the count limit.
  always_comb begin
    step_val = o_Count;
    carry    = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (!i_DIR)
          step_val[4*k +: 4] = (o_Count[4*k +: 4] == DMAX) ? 4'd0 : o_Count[4*k +: 4] + 4'd1;
        else
          step_val[4*k +: 4] = (o_Count[4*k +: 4] == 4'd0) ? DMAX : o_Count[4*k +: 4] - 4'd1;
      end
      carry = carry && (i_DIR ? (o_Count[4*k +: 4] == 4'd0) : (o_Count[4*k +: 4] == DMAX));
    end
  end

  always_comb begin
    load_clamped = '0;
    for (int k = 0; k < DIGITS; k++)
      load_clamped[4*k +: 4] = (i_LOAD_VAL[4*k +: 4] > DMAX) ? DMAX : i_LOAD_VAL[4*k +: 4];
  end

  // A load suppresses the tick, so it can never produce a wrap.
  assign wrap_event = tick && !i_LOAD && carry;

  // Start/lap decode; i_START wins over i_LAP.
  always_comb begin
    state_fsm = state_q;
    lap_enter = 1'b0;
    if (i_START) begin
      state_fsm = (state_q == ST_STOPPED) ? ST_RUNNING : ST_STOPPED;
    end else if (i_LAP) begin
      if (state_q == ST_RUNNING) begin
        state_fsm = ST_LAP;
        lap_enter = 1'b1;
      end else if (state_q == ST_LAP) begin
        state_fsm = ST_RUNNING;
      end
    end
  end

  // Full next state, including reset and soft clear, so the state flags can be
  // registered alongside the state itself.
  always_comb begin
    state_n = state_fsm;
    if (i_RST)
      state_n = ST_STOPPED;
    else if (i_SRST)
      state_n = (state_q == ST_LAP) ? ST_RUNNING : state_q;
    else if (wrap_event && (COUNT_SAT != 0))
      state_n = ST_STOPPED;
  end

  always_ff @(posedge i_SUBCLK) begin
    state_q      <= state_n;
    o_Running    <= (state_n != ST_STOPPED);
    o_Lap_Active <= (state_n == ST_LAP);
    if (i_RST) begin
      o_Count <= '0;
      lap_q   <= '0;
      o_Wrap  <= 1'b0;
    end else if (i_SRST) begin
      o_Count <= '0;
      lap_q   <= '0;
      o_Wrap  <= 1'b0;
    end else begin
      o_Wrap <= wrap_event;
      // Lap captures the pre-tick count.
      if (lap_enter)
        lap_q <= o_Count;
      if (i_LOAD)
        o_Count <= load_clamped;
      else if (tick && !(carry && (COUNT_SAT != 0)))
        o_Count <= step_val;
    end
  end

  assign o_Display = o_Lap_Active ? lap_q : o_Count;
  assign o_Zero    = (o_Count == '0);

endmodule

// File: tb/tb_stopwatch_multidigit_counter.sv
module tb_stopwatch_multidigit_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0, srst = 1'b0, en = 1'b0, start = 1'b0, lap = 1'b0, dir = 1'b0, load = 1'b0;
  logic [15:0] load_val = '0;

  logic [15:0] c0, d0, c2, d2;
  logic [7:0]  c1, d1;
  logic        r0, l0, w0, z0, r1, l1, w1, z1, r2, l2, w2, z2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // default: 4 decimal digits, wrap
  stopwatch_multidigit_counter u_dut (
    .i_SUBCLK(clk), .i_RST(rst), .i_SRST(srst), .i_CLK_EN(en), .i_START(start), .i_LAP(lap),
    .i_DIR(dir), .i_LOAD(load), .i_LOAD_VAL(load_val), .o_Count(c0), .o_Display(d0),
    .o_Running(r0), .o_Lap_Active(l0), .o_Wrap(w0), .o_Zero(z0));

  // 2 hex digits, wrap
  stopwatch_multidigit_counter #(.DIGITS(2), .DIGIT_MAX(15), .COUNT_SAT(0)) u_hex (
    .i_SUBCLK(clk), .i_RST(rst), .i_SRST(srst), .i_CLK_EN(en), .i_START(start), .i_LAP(lap),
    .i_DIR(dir), .i_LOAD(load), .i_LOAD_VAL(load_val[7:0]), .o_Count(c1), .o_Display(d1),
    .o_Running(r1), .o_Lap_Active(l1), .o_Wrap(w1), .o_Zero(z1));

  // 4 decimal digits, saturate
  stopwatch_multidigit_counter #(.DIGITS(4), .DIGIT_MAX(9), .COUNT_SAT(1)) u_sat (
    .i_SUBCLK(clk), .i_RST(rst), .i_SRST(srst), .i_CLK_EN(en), .i_START(start), .i_LAP(lap),
    .i_DIR(dir), .i_LOAD(load), .i_LOAD_VAL(load_val), .o_Count(c2), .o_Display(d2),
    .o_Running(r2), .o_Lap_Active(l2), .o_Wrap(w2), .o_Zero(z2));

  logic [31:0] act_cnt [3];
  logic [31:0] act_disp[3];
  logic [3:0]  act_flg [3];
  assign act_cnt[0]  = {16'd0, c0};
  assign act_cnt[1]  = {24'd0, c1};
  assign act_cnt[2]  = {16'd0, c2};
  assign act_disp[0] = {16'd0, d0};
  assign act_disp[1] = {24'd0, d1};
  assign act_disp[2] = {16'd0, d2};
  assign act_flg[0]  = {r0, l0, w0, z0};
  assign act_flg[1]  = {r1, l1, w1, z1};
  assign act_flg[2]  = {r2, l2, w2, z2};

  // Reference model: the count is an integer in base DIGIT_MAX+1, the state is
  // 0 = stopped, 1 = running, 2 = lap.
  typedef struct {
    int cnt;
    int lapv;
    int st;
    bit wrap;
  } mdl_t;

  mdl_t m[3];
  int   cfg_dig[3] = '{4, 2, 4};
  int   cfg_max[3] = '{9, 15, 9};
  int   cfg_sat[3] = '{0, 0, 1};

  function automatic int pw(int b, int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic int lv_to_int(logic [31:0] v, int dig, int dmax);
    int r = 0;
    for (int k = 0; k < dig; k++) begin
      int d = int'(v[4*k +: 4]);
      if (d > dmax) d = dmax;
      r = r + d * pw(dmax + 1, k);
    end
    return r;
  endfunction

  function automatic logic [31:0] int_to_lv(int v, int dig, int dmax);
    logic [31:0] r = '0;
    for (int k = 0; k < dig; k++)
      r[4*k +: 4] = 4'((v / pw(dmax + 1, k)) % (dmax + 1));
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t s, int dig, int dmax, int sat);
    mdl_t n   = s;
    int   lim = pw(dmax + 1, dig);
    n.wrap = 1'b0;
    if (rst) begin
      n.cnt = 0; n.lapv = 0; n.st = 0;
    end else if (srst) begin
      n.cnt = 0; n.lapv = 0;
      if (s.st == 2) n.st = 1;
    end else begin
      if (start) n.st = (s.st == 0) ? 1 : 0;
      else if (lap) begin
        if (s.st == 1) begin n.st = 2; n.lapv = s.cnt; end
        else if (s.st == 2) n.st = 1;
      end
      if (load) n.cnt = lv_to_int({16'd0, load_val}, dig, dmax);
      else if (en && s.st != 0) begin
        if ((!dir && s.cnt == lim - 1) || (dir && s.cnt == 0)) begin
          n.wrap = 1'b1;
          if (sat != 0) n.st = 0;
          else n.cnt = dir ? lim - 1 : 0;
        end else begin
          n.cnt = dir ? s.cnt - 1 : s.cnt + 1;
        end
      end
    end
    return n;
  endfunction

  // One clock edge; the model follows every edge so it stays in step with all instances.
  task automatic cyc();
    @(posedge clk);
    for (int i = 0; i < 3; i++) m[i] = mstep(m[i], cfg_dig[i], cfg_max[i], cfg_sat[i]);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b1; load = 1'b1; load_val = 16'h1234; srst = 1'b1; en = 1'b1;
    rst = 1'b1; cyc(); cyc();
    rst = 1'b0; start = 1'b0; load = 1'b0; srst = 1'b0; en = 1'b0;
    n_tests++; if (c0 !== 16'h0000) begin n_fail++; $display("FAIL reset_count got %h want 0000", c0); end
    n_tests++; if (d0 !== 16'h0000) begin n_fail++; $display("FAIL reset_display got %h want 0000", d0); end
    n_tests++; if ({r0, l0, w0, z0} !== 4'b0001) begin n_fail++; $display("FAIL reset_flags got %b want 0001", {r0, l0, w0, z0}); end
    n_tests++; if ({c1, r1, z1} !== {8'h00, 1'b0, 1'b1}) begin n_fail++; $display("FAIL reset_hex got %h/%b/%b want 00/0/1", c1, r1, z1); end
  endtask

  task automatic test_count_up();
    logic [15:0] exp;
    do_reset();
    dir = 1'b0; start = 1'b1; cyc(); start = 1'b0;
    n_tests++; if (r0 !== 1'b1 || c0 !== 16'h0000) begin n_fail++; $display("FAIL start_run got run=%b cnt=%h want 1/0000", r0, c0); end
    en = 1'b1;
    for (int i = 1; i <= 10000; i++) begin
      cyc();
      exp = 16'(int_to_lv(i % 10000, 4, 9));
      n_tests++; if (c0 !== exp) begin n_fail++; $display("FAIL up_count step %0d got %h want %h", i, c0, exp); end
      n_tests++; if (w0 !== (i == 10000)) begin n_fail++; $display("FAIL up_wrap step %0d got %b want %b", i, w0, (i == 10000)); end
    end
    en = 1'b0;
    n_tests++; if (z0 !== 1'b1) begin n_fail++; $display("FAIL up_zero got %b want 1", z0); end
    cyc();
    n_tests++; if (w0 !== 1'b0) begin n_fail++; $display("FAIL wrap_single_cycle got %b want 0", w0); end
  endtask

  task automatic test_hex_down();
    do_reset();
    dir = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    en = 1'b1; cyc();
    n_tests++; if (c1 !== 8'hFF || w1 !== 1'b1) begin n_fail++; $display("FAIL hex_down_wrap got %h/%b want FF/1", c1, w1); end
    n_tests++; if (c0 !== 16'h9999 || w0 !== 1'b1) begin n_fail++; $display("FAIL dec_down_wrap got %h/%b want 9999/1", c0, w0); end
    cyc();
    n_tests++; if (c1 !== 8'hFE || w1 !== 1'b0) begin n_fail++; $display("FAIL hex_down_next got %h/%b want FE/0", c1, w1); end
    en = 1'b0; dir = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    load = 1'b1; load_val = 16'h9999; cyc(); load = 1'b0;
    n_tests++; if (c2 !== 16'h9999 || r2 !== 1'b1) begin n_fail++; $display("FAIL sat_load got %h/%b want 9999/1", c2, r2); end
    en = 1'b1; cyc();
    n_tests++; if (c2 !== 16'h9999 || w2 !== 1'b1 || r2 !== 1'b0) begin n_fail++; $display("FAIL sat_hit got %h/w%b/r%b want 9999/1/0", c2, w2, r2); end
    cyc(); cyc();
    n_tests++; if (c2 !== 16'h9999 || w2 !== 1'b0) begin n_fail++; $display("FAIL sat_hold got %h/%b want 9999/0", c2, w2); end
    en = 1'b0;
  endtask

  task automatic test_lap();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    load = 1'b1; load_val = 16'h0123; cyc(); load = 1'b0;
    lap = 1'b1; cyc(); lap = 1'b0;
    n_tests++; if (l0 !== 1'b1 || d0 !== 16'h0123) begin n_fail++; $display("FAIL lap_enter got %b/%h want 1/0123", l0, d0); end
    en = 1'b1; repeat (5) cyc(); en = 1'b0;
    n_tests++; if (d0 !== 16'h0123 || c0 !== 16'h0128) begin n_fail++; $display("FAIL lap_frozen got disp %h cnt %h want 0123/0128", d0, c0); end
    lap = 1'b1; cyc(); lap = 1'b0;
    n_tests++; if (d0 !== 16'h0128 || l0 !== 1'b0 || r0 !== 1'b1) begin n_fail++; $display("FAIL lap_exit got %h/l%b/r%b want 0128/0/1", d0, l0, r0); end
  endtask

  task automatic test_load_clamp();
    load = 1'b1; load_val = 16'hA5C3; en = 1'b1; cyc(); load = 1'b0; en = 1'b0;
    n_tests++; if (c0 !== 16'h9593 || w0 !== 1'b0) begin n_fail++; $display("FAIL load_clamp got %h/%b want 9593/0", c0, w0); end
    n_tests++; if (c1 !== 8'hC3) begin n_fail++; $display("FAIL load_hex got %h want C3", c1); end
  endtask

  task automatic test_start_lap_priority();
    start = 1'b1; lap = 1'b1; cyc(); start = 1'b0; lap = 1'b0;
    n_tests++; if (r0 !== 1'b0 || l0 !== 1'b0) begin n_fail++; $display("FAIL start_over_lap got r%b l%b want 0/0", r0, l0); end
    lap = 1'b1; cyc(); lap = 1'b0;
    n_tests++; if (r0 !== 1'b0 || l0 !== 1'b0) begin n_fail++; $display("FAIL lap_in_stopped got r%b l%b want 0/0", r0, l0); end
  endtask

  task automatic test_srst_rst();
    start = 1'b1; cyc(); start = 1'b0;
    load = 1'b1; load_val = 16'h0456; cyc(); load = 1'b0;
    lap = 1'b1; cyc(); lap = 1'b0;
    n_tests++; if (l0 !== 1'b1 || d0 !== 16'h0456) begin n_fail++; $display("FAIL srst_setup got %b/%h want 1/0456", l0, d0); end
    srst = 1'b1; lap = 1'b1; cyc(); srst = 1'b0; lap = 1'b0;
    n_tests++; if (c0 !== 16'h0 || d0 !== 16'h0 || l0 !== 1'b0 || r0 !== 1'b1) begin n_fail++; $display("FAIL srst_lap got %h/%h/l%b/r%b want 0000/0000/0/1", c0, d0, l0, r0); end
    load = 1'b1; load_val = 16'h0777; cyc(); load = 1'b0;
    start = 1'b1; load = 1'b1; load_val = 16'h1234; srst = 1'b1; en = 1'b1; rst = 1'b1;
    cyc();
    start = 1'b0; load = 1'b0; srst = 1'b0; en = 1'b0; rst = 1'b0;
    n_tests++; if ({c0, d0} !== 32'h0 || {r0, l0, w0, z0} !== 4'b0001) begin n_fail++; $display("FAIL rst_override got %h/%h/%b want 0/0/0001", c0, d0, {r0, l0, w0, z0}); end
  endtask

  task automatic test_random();
    logic [31:0] ec, ed;
    logic [3:0]  ef;
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      en       = ($urandom % 4) != 0;
      start    = ($urandom % 20) == 0;
      lap      = ($urandom % 10) == 0;
      if (($urandom % 60) == 0) dir = ~dir;
      load     = ($urandom % 40) == 0;
      load_val = 16'($urandom);
      srst     = ($urandom % 150) == 0;
      rst      = ($urandom % 700) == 0;
      cyc();
      for (int i = 0; i < 3; i++) begin
        ec = int_to_lv(m[i].cnt, cfg_dig[i], cfg_max[i]);
        ed = (m[i].st == 2) ? int_to_lv(m[i].lapv, cfg_dig[i], cfg_max[i]) : ec;
        ef = {m[i].st != 0, m[i].st == 2, m[i].wrap, m[i].cnt == 0};
        n_tests++; if (act_cnt[i] !== ec) begin n_fail++; $display("FAIL rand_count inst %0d cyc %0d got %h want %h", i, t, act_cnt[i], ec); end
        n_tests++; if (act_disp[i] !== ed) begin n_fail++; $display("FAIL rand_display inst %0d cyc %0d got %h want %h", i, t, act_disp[i], ed); end
        n_tests++; if (act_flg[i] !== ef) begin n_fail++; $display("FAIL rand_flags inst %0d cyc %0d got %b want %b", i, t, act_flg[i], ef); end
      end
    end
    en = 1'b0; start = 1'b0; lap = 1'b0; load = 1'b0; srst = 1'b0; rst = 1'b0; dir = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) m[i] = '{cnt: 0, lapv: 0, st: 0, wrap: 1'b0};
    test_reset();
    test_count_up();
    test_hex_down();
    test_saturate();
    test_lap();
    test_load_clamp();
    test_start_lap_priority();
    test_srst_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
